// File: rtl/ifid_hazard_ctrl.sv
// Hazard/flush sequencer for the IF/ID latch and PC: arbitrates mispredict, data-memory stall,
// load-use hazard, fetch stall and halt, and drives the latch/PC/bubble controls (Mealy outputs).
module ifid_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned LU_CYCLES    = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_id_rs_valid,
  input  logic [2:0]       i_id_rs,
  input  logic             i_id_rt_valid,
  input  logic [2:0]       i_id_rt,
  input  logic             i_idex_memread,
  input  logic [2:0]       i_idex_rd,
  input  logic             i_ex_mispredict,
  input  logic             i_imem_stall,
  input  logic             i_dmem_stall,
  input  logic             i_halt_req,
  output logic             o_nop_mech,
  output logic             o_nop_branch,
  output logic             o_fetch_stall,
  output logic             o_pc_we,
  output logic             o_pc_redirect,
  output logic             o_idex_bubble,
  output logic             o_pipe_freeze,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count
);

  localparam int unsigned MAX_CYC = (FLUSH_CYCLES > LU_CYCLES) ? FLUSH_CYCLES : LU_CYCLES;
  localparam int unsigned SEQ_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    S_RUN,
    S_LU_STALL,
    S_FLUSH,
    S_MEM_WAIT,
    S_HALT
  } state_t;

  state_t             r_state;
  state_t             r_ret_state;
  logic [SEQ_W-1:0]   r_seq_cnt;
  logic [CNT_W-1:0]   r_stall_count;
  logic [CNT_W-1:0]   r_flush_count;

  state_t             w_eff_state;
  state_t             w_next_state;
  state_t             w_next_ret;
  logic [SEQ_W-1:0]   w_next_cnt;
  logic               w_flush_evt;
  logic               w_hazard;

  assign w_hazard = i_idex_memread &
                    ((i_id_rs_valid & (i_id_rs == i_idex_rd)) |
                     (i_id_rt_valid & (i_id_rt == i_idex_rd)));

  // MEM_WAIT behaves as the frozen state once the data memory becomes ready
  assign w_eff_state = (r_state == S_MEM_WAIT) ? r_ret_state : r_state;

  assign o_stall_count = r_stall_count;
  assign o_flush_count = r_flush_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_ret_state   <= S_RUN;
      r_seq_cnt     <= '0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      r_state     <= w_next_state;
      r_ret_state <= w_next_ret;
      r_seq_cnt   <= w_next_cnt;
      if (!o_pc_we && !o_halted && (r_stall_count != '1))
        r_stall_count <= r_stall_count + CNT_W'(1);
      if (w_flush_evt && (r_flush_count != '1))
        r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_ret    = r_ret_state;
    w_next_cnt    = r_seq_cnt;
    w_flush_evt   = 1'b0;
    o_nop_mech    = 1'b0;
    o_nop_branch  = 1'b0;
    o_fetch_stall = 1'b0;
    o_pc_we       = 1'b1;
    o_pc_redirect = 1'b0;
    o_idex_bubble = 1'b0;
    o_pipe_freeze = 1'b0;
    o_halted      = 1'b0;
    if (!rst) begin
      if (w_eff_state == S_HALT) begin
        o_halted     = 1'b1;
        o_nop_mech   = 1'b1;
        o_pc_we      = 1'b0;
        w_next_state = S_HALT;
      end else if (i_ex_mispredict) begin
        // wrong-path events in this cycle are dropped
        o_nop_branch  = 1'b1;
        o_pc_redirect = 1'b1;
        o_idex_bubble = 1'b1;
        w_flush_evt   = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          w_next_state = S_FLUSH;
          w_next_cnt   = SEQ_W'(FLUSH_CYCLES - 1);
        end else begin
          w_next_state = S_RUN;
        end
      end else if (i_dmem_stall) begin
        o_pipe_freeze = 1'b1;
        o_nop_mech    = 1'b1;
        o_pc_we       = 1'b0;
        w_next_state  = S_MEM_WAIT;
        w_next_ret    = w_eff_state;
      end else begin
        case (w_eff_state)
          S_FLUSH: begin
            o_nop_branch = 1'b1;
            w_next_cnt   = r_seq_cnt - SEQ_W'(1);
            w_next_state = (r_seq_cnt <= SEQ_W'(1)) ? S_RUN : S_FLUSH;
          end
          S_LU_STALL: begin
            o_nop_mech    = 1'b1;
            o_pc_we       = 1'b0;
            o_idex_bubble = 1'b1;
            w_next_cnt    = r_seq_cnt - SEQ_W'(1);
            w_next_state  = (r_seq_cnt <= SEQ_W'(1)) ? S_RUN : S_LU_STALL;
          end
          default: begin
            w_next_state = S_RUN;
            if (w_hazard) begin
              o_nop_mech    = 1'b1;
              o_pc_we       = 1'b0;
              o_idex_bubble = 1'b1;
              if (LU_CYCLES > 1) begin
                w_next_state = S_LU_STALL;
                w_next_cnt   = SEQ_W'(LU_CYCLES - 1);
              end
            end else if (i_imem_stall) begin
              o_fetch_stall = 1'b1;
              o_pc_we       = 1'b0;
            end else if (i_halt_req) begin
              o_nop_mech    = 1'b1;
              o_pc_we       = 1'b0;
              o_idex_bubble = 1'b1;
              w_next_state  = S_HALT;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Bench for ifid_hazard_ctrl: two parameterisations driven in parallel, directed scenarios
// then random traffic, each checked against an event-level reference model.
module tb_ifid_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_rs_valid, id_rt_valid, idex_memread;
  logic [2:0] id_rs, id_rt, idex_rd;
  logic       ex_mispredict, imem_stall, dmem_stall, halt_req;

  // output vector order: nop_mech, nop_branch, fetch_stall, pc_we, pc_redirect, idex_bubble, pipe_freeze, halted
  localparam logic [7:0] O_IDLE  = 8'b0001_0000;
  localparam logic [7:0] O_MISP  = 8'b0101_1100;
  localparam logic [7:0] O_DMEM  = 8'b1000_0010;
  localparam logic [7:0] O_FLUSH = 8'b0101_0000;
  localparam logic [7:0] O_STALL = 8'b1000_0100;
  localparam logic [7:0] O_IMEM  = 8'b0010_0000;
  localparam logic [7:0] O_HALT  = 8'b1000_0001;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int m_fl_cyc [2] = '{2, 3};
  int m_lu_cyc [2] = '{1, 2};
  int m_cmax   [2] = '{65535, 15};
  int m_flush_left [2];
  int m_lu_left    [2];
  bit m_halted     [2];
  int m_sc         [2];
  int m_fc         [2];

  logic [7:0]  obs_o  [2];
  logic [31:0] obs_sc [2];
  logic [31:0] obs_fc [2];

  logic        a_nm, a_nb, a_fs, a_we, a_pr, a_ib, a_pf, a_h;
  logic        b_nm, b_nb, b_fs, b_we, b_pr, b_ib, b_pf, b_h;
  logic [15:0] a_sc, a_fc;
  logic [3:0]  b_sc, b_fc;

  always #5 clk = ~clk;

  ifid_hazard_ctrl #(.FLUSH_CYCLES(2), .LU_CYCLES(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst),
    .i_id_rs_valid(id_rs_valid), .i_id_rs(id_rs), .i_id_rt_valid(id_rt_valid), .i_id_rt(id_rt),
    .i_idex_memread(idex_memread), .i_idex_rd(idex_rd), .i_ex_mispredict(ex_mispredict),
    .i_imem_stall(imem_stall), .i_dmem_stall(dmem_stall), .i_halt_req(halt_req),
    .o_nop_mech(a_nm), .o_nop_branch(a_nb), .o_fetch_stall(a_fs), .o_pc_we(a_we),
    .o_pc_redirect(a_pr), .o_idex_bubble(a_ib), .o_pipe_freeze(a_pf), .o_halted(a_h),
    .o_stall_count(a_sc), .o_flush_count(a_fc)
  );

  ifid_hazard_ctrl #(.FLUSH_CYCLES(3), .LU_CYCLES(2), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .i_id_rs_valid(id_rs_valid), .i_id_rs(id_rs), .i_id_rt_valid(id_rt_valid), .i_id_rt(id_rt),
    .i_idex_memread(idex_memread), .i_idex_rd(idex_rd), .i_ex_mispredict(ex_mispredict),
    .i_imem_stall(imem_stall), .i_dmem_stall(dmem_stall), .i_halt_req(halt_req),
    .o_nop_mech(b_nm), .o_nop_branch(b_nb), .o_fetch_stall(b_fs), .o_pc_we(b_we),
    .o_pc_redirect(b_pr), .o_idex_bubble(b_ib), .o_pipe_freeze(b_pf), .o_halted(b_h),
    .o_stall_count(b_sc), .o_flush_count(b_fc)
  );

  assign obs_o[0]  = {a_nm, a_nb, a_fs, a_we, a_pr, a_ib, a_pf, a_h};
  assign obs_o[1]  = {b_nm, b_nb, b_fs, b_we, b_pr, b_ib, b_pf, b_h};
  assign obs_sc[0] = 32'(a_sc);
  assign obs_sc[1] = 32'(b_sc);
  assign obs_fc[0] = 32'(a_fc);
  assign obs_fc[1] = 32'(b_fc);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_idle();
    id_rs_valid = 0; id_rs = 0; id_rt_valid = 0; id_rt = 0;
    idex_memread = 0; idex_rd = 0;
    ex_mispredict = 0; imem_stall = 0; dmem_stall = 0; halt_req = 0;
  endtask

  task automatic set_random();
    id_rs_valid   = 1'($urandom_range(0, 1));
    id_rs         = 3'($urandom_range(0, 3));
    id_rt_valid   = 1'($urandom_range(0, 1));
    id_rt         = 3'($urandom_range(0, 3));
    idex_memread  = ($urandom_range(0, 2) == 0);
    idex_rd       = 3'($urandom_range(0, 3));
    ex_mispredict = ($urandom_range(0, 9) == 0);
    dmem_stall    = ($urandom_range(0, 6) == 0);
    imem_stall    = ($urandom_range(0, 4) == 0);
    halt_req      = ($urandom_range(0, 59) == 0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_flush_left[k] = 0; m_lu_left[k] = 0; m_halted[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  // Event-level reference: pending flush/load-use cycle budgets; a memory stall just pauses them
  task automatic model_step(input int k);
    logic [7:0] e;
    bit hz;
    bit misp;
    hz = idex_memread && ((id_rs_valid && id_rs == idex_rd) || (id_rt_valid && id_rt == idex_rd));
    misp = 0;
    e = O_IDLE;
    if (m_halted[k]) e = O_HALT;
    else if (ex_mispredict) begin
      e = O_MISP; misp = 1;
      m_flush_left[k] = m_fl_cyc[k] - 1; m_lu_left[k] = 0;
    end else if (dmem_stall) e = O_DMEM;
    else if (m_flush_left[k] > 0) begin e = O_FLUSH; m_flush_left[k]--; end
    else if (m_lu_left[k] > 0) begin e = O_STALL; m_lu_left[k]--; end
    else if (hz) begin e = O_STALL; m_lu_left[k] = m_lu_cyc[k] - 1; end
    else if (imem_stall) e = O_IMEM;
    else if (halt_req) begin e = O_STALL; m_halted[k] = 1; end
    check_val(k == 0 ? "outs_a" : "outs_b", 32'(obs_o[k]), 32'(e));
    check_val(k == 0 ? "stall_cnt_a" : "stall_cnt_b", obs_sc[k], 32'(m_sc[k]));
    check_val(k == 0 ? "flush_cnt_a" : "flush_cnt_b", obs_fc[k], 32'(m_fc[k]));
    if (!e[4] && !e[0] && m_sc[k] < m_cmax[k]) m_sc[k]++;
    if (misp && m_fc[k] < m_cmax[k]) m_fc[k]++;
  endtask

  // Inputs are applied just after posedge; outputs checked at negedge+1
  task automatic cycle();
    @(negedge clk);
    #1;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_val({tag, "_outs_a"}, 32'(obs_o[0]), 32'(O_IDLE));
    check_val({tag, "_outs_b"}, 32'(obs_o[1]), 32'(O_IDLE));
    check_val({tag, "_cnt_a"}, 32'({a_sc, a_fc}), 32'd0);
    check_val({tag, "_cnt_b"}, 32'({b_sc, b_fc}), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_outs_a", 32'(obs_o[0]), 32'(O_IDLE));
    check_val("reset_stall_cnt_a", 32'(a_sc), 32'd0);
    rst = 1'b0;

    // load-use: LW r2 in EX, ID reads rs=r2
    idex_memread = 1; idex_rd = 3'd2; id_rs_valid = 1; id_rs = 3'd2;
    cycle();
    check_val("lu_stall_cnt_a", 32'(a_sc), 32'd1);
    cycle();
    check_val("lu_stall_cnt_b", 32'(b_sc), 32'd2);
    set_idle();
    repeat (3) cycle();

    // mispredict together with halt_req: halt is wrong-path
    ex_mispredict = 1; halt_req = 1;
    cycle();
    set_idle();
    repeat (3) cycle();
    check_val("misp_halt_halted_a", 32'(a_h), 32'd0);
    check_val("misp_flush_cnt_a", 32'(a_fc), 32'd1);

    // data-memory stall held 3 cycles in the middle of a flush
    ex_mispredict = 1;
    cycle();
    ex_mispredict = 0; dmem_stall = 1;
    repeat (3) cycle();
    dmem_stall = 0;
    repeat (4) cycle();

    // halt, then fetch stalls toggling, then async reset
    halt_req = 1;
    cycle();
    halt_req = 0;
    for (int i = 0; i < 4; i++) begin
      imem_stall = 1'(i % 2);
      cycle();
    end
    check_val("halt_sticky_a", 32'(a_h), 32'd1);
    async_reset("halt_rst");
    set_idle();

    // random traffic with occasional mid-cycle reset
    for (int i = 0; i < 4000; i++) begin
      set_random();
      if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
